// File: rtl/uart_tx_stim.sv
// UART 8N1/8N2 transmitter fed by a small circular write FIFO.
// Serialises bytes LSB first at a fixed clocks-per-bit ratio; line idles high.
module uart_tx_stim #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 3,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [7:0]            wdata_i,
  input  logic                  wvalid_i,
  output logic                  wready_o,
  output logic [DEPTH_LOG2:0]   level_o,
  output logic                  busy_o,
  output logic                  txd_o
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL      = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] LVL_ONE   = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = (DEPTH_LOG2)'(1);
  localparam logic [15:0]         RELOAD    = 16'(CLKS_PER_BIT - 1);
  localparam logic                STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level;
  logic [15:0]           timer;
  logic [2:0]            bit_cnt;
  logic                  stop_cnt;
  logic [7:0]            shift;
  logic                  push;
  logic                  pop;
  logic                  tick;
  logic                  frame_done;

  assign wready_o   = level != FULL;
  assign level_o    = level;
  assign push       = wvalid_i & wready_o;
  assign tick       = timer == 16'd0;
  assign frame_done = (state == STOP) && tick && (stop_cnt == STOP_LAST);
  // The FSM pops either from idle or exactly at the last stop cycle, so the
  // next start bit follows the previous stop bit with no gap.
  assign pop        = (level != '0) && ((state == IDLE) || frame_done);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      level <= level + LVL_ONE;
      else if (pop && !push) level <= level - LVL_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      timer    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      txd_o    <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          txd_o <= 1'b1;
          if (pop) begin
            shift  <= mem[rd_ptr];
            txd_o  <= 1'b0;
            timer  <= RELOAD;
            busy_o <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          if (tick) begin
            txd_o   <= shift[0];
            timer   <= RELOAD;
            bit_cnt <= '0;
            state   <= DATA;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        DATA: begin
          if (tick) begin
            timer <= RELOAD;
            if (bit_cnt == 3'd7) begin
              txd_o    <= 1'b1;
              stop_cnt <= 1'b0;
              state    <= STOP;
            end else begin
              // shift[0] is on the line now; shift[1] is the next bit out
              shift   <= shift >> 1;
              txd_o   <= shift[1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        STOP: begin
          if (tick) begin
            timer <= RELOAD;
            if (stop_cnt == STOP_LAST) begin
              if (pop) begin
                shift <= mem[rd_ptr];
                txd_o <= 1'b0;
                state <= START;
              end else begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_stim.sv
// Bench for uart_tx_stim: three parameterisations checked cycle by cycle
// against a frame-timeline model built from accept times and bytes.
module tb_uart_tx_stim;

  logic       clk;
  logic       rst;
  logic       wv;
  logic [7:0] wd;
  int         sel;
  int         cyc;

  logic       wv0, wv1, wv2;
  logic       wready0, wready1, wready2;
  logic [3:0] level0, level1, level2;
  logic       busy0, busy1, busy2;
  logic       txd0, txd1, txd2;
  logic [6:0] obs;

  int checks;
  int errors;

  // model state
  int         m_acc[$];
  int         m_start[$];
  logic [7:0] m_data[$];
  int         last_end;
  int         cpb;
  int         fl;

  assign wv0 = wv && (sel == 0);
  assign wv1 = wv && (sel == 1);
  assign wv2 = wv && (sel == 2);

  uart_tx_stim u_dut0 (
    .clk_i(clk), .rst_i(rst), .wdata_i(wd), .wvalid_i(wv0), .wready_o(wready0),
    .level_o(level0), .busy_o(busy0), .txd_o(txd0));

  uart_tx_stim #(.CLKS_PER_BIT(4), .DEPTH_LOG2(3), .STOP_BITS(2)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .wdata_i(wd), .wvalid_i(wv1), .wready_o(wready1),
    .level_o(level1), .busy_o(busy1), .txd_o(txd1));

  uart_tx_stim #(.CLKS_PER_BIT(2), .DEPTH_LOG2(3), .STOP_BITS(1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .wdata_i(wd), .wvalid_i(wv2), .wready_o(wready2),
    .level_o(level2), .busy_o(busy2), .txd_o(txd2));

  always_comb begin
    obs = {txd0, busy0, wready0, level0};
    if (sel == 1) obs = {txd1, busy1, wready1, level1};
    else if (sel == 2) obs = {txd2, busy2, wready2, level2};
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // {txd, busy, wready, level} expected just after edge n
  function automatic logic [6:0] exp_vec(input int n);
    logic t;
    logic b;
    int lv;
    int bi;
    logic [7:0] d;
    t = 1'b1; b = 1'b0; lv = 0;
    for (int k = 0; k < m_start.size(); k++) begin
      if (m_acc[k] <= n && m_start[k] > n) lv++;
      if (n >= m_start[k] && n < m_start[k] + fl) begin
        b  = 1'b1;
        bi = (n - m_start[k]) / cpb;
        d  = m_data[k];
        if (bi == 0) t = 1'b0;
        else if (bi <= 8) t = d[bi-1];
        else t = 1'b1;
      end
    end
    return {t, b, (lv != 8), 4'(lv)};
  endfunction

  function automatic void model_clear();
    m_acc.delete(); m_start.delete(); m_data.delete();
    last_end = 0;
  endfunction

  function automatic void set_cfg(input int c, input int s);
    cpb = c;
    fl  = (9 + s) * c;
  endfunction

  // drive one cycle of stimulus; the model decides acceptance from its own level
  task automatic step(input logic v, input logic [7:0] d, output logic acc);
    int n;
    int s;
    logic [6:0] e;
    n  = cyc;
    wv = v;
    wd = d;
    e  = exp_vec(n);
    acc = v && (e[3:0] != 4'd8);
    if (acc) begin
      s = (n + 2 > last_end) ? n + 2 : last_end;
      m_acc.push_back(n + 1);
      m_start.push_back(s);
      m_data.push_back(d);
      last_end = s + fl;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wv  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    set_cfg(16, 1);
    sel = 0;
    do_reset();
    do_reset();
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      checks++;
      if (obs !== 7'b1010000) begin
        errors++;
        $display("FAIL reset dut%0d got=%b exp=%b", s, obs, 7'b1010000);
      end
    end
    sel = 0;
  endtask

  task automatic test_single_byte();
    logic acc;
    int t0;
    sel = 0; set_cfg(16, 1); do_reset();
    step(1'b1, 8'h55, acc);
    t0 = cyc;
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL single_vec cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      if (cyc == t0) begin
        checks++;
        if (obs[3:0] !== 4'd1) begin
          errors++; $display("FAIL single_level_e0 got=%0d exp=1", obs[3:0]);
        end
      end
      if (cyc == t0 + 160 || cyc == t0 + 161) begin
        checks++;
        if (obs[5] !== (cyc == t0 + 160)) begin
          errors++; $display("FAIL single_busy cyc=%0d got=%b", cyc - t0, obs[5]);
        end
      end
      for (int i = 0; i < 10; i++) begin
        if (cyc == t0 + 1 + 16 * i + 8) begin
          checks++;
          if (obs[6] !== 1'(i % 2)) begin
            errors++; $display("FAIL single_bit%0d got=%b exp=%0d", i, obs[6], i % 2);
          end
        end
      end
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic test_bit_order();
    logic acc;
    int t0;
    int ord[8] = '{1, 1, 0, 0, 0, 1, 0, 1};
    sel = 0; set_cfg(16, 1); do_reset();
    step(1'b1, 8'hA3, acc);
    t0 = cyc;
    for (int k = 0; k < 220; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL order_vec cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      for (int i = 0; i < 8; i++) begin
        if (cyc == t0 + 1 + 16 * (i + 1) + 8) begin
          checks++;
          if (obs[6] !== 1'(ord[i])) begin
            errors++; $display("FAIL order_d%0d got=%b exp=%0d", i, obs[6], ord[i]);
          end
        end
      end
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic test_full_fifo();
    logic acc;
    int i;
    int t0;
    sel = 0; set_cfg(16, 1); do_reset();
    i = 0; t0 = -1000;
    for (int k = 0; k < 1800; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL full_vec cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      if (cyc == t0 + 8) begin
        checks++;
        if (obs[4:0] !== 5'b01000) begin
          errors++; $display("FAIL full_at_e8 got=%b exp=01000", obs[4:0]);
        end
      end
      if (cyc == t0 + 161) begin
        checks++;
        if (obs[4:0] !== 5'b10111) begin
          errors++; $display("FAIL full_at_e161 got=%b exp=10111", obs[4:0]);
        end
      end
      if (i < 10) begin
        step(1'b1, 8'(i + 1), acc);
        if (acc) begin
          if (i == 0) t0 = cyc;
          i++;
        end
      end else begin
        step(1'b0, 8'($urandom), acc);
      end
    end
  endtask

  task automatic test_two_stop();
    logic acc;
    int t0;
    sel = 1; set_cfg(4, 2); do_reset();
    step(1'b1, 8'hFF, acc);
    t0 = cyc;
    step(1'b1, 8'hFF, acc);
    for (int k = 0; k < 120; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL stop2_vec cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      if (cyc == t0 + 4 || cyc == t0 + 5 || cyc == t0 + 44 || cyc == t0 + 45 || cyc == t0 + 48) begin
        checks++;
        if (obs[6] !== (cyc == t0 + 5 || cyc == t0 + 44)) begin
          errors++; $display("FAIL stop2_line t=%0d got=%b", cyc - t0, obs[6]);
        end
      end
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic test_reset_mid();
    logic acc;
    int t0;
    sel = 0; set_cfg(16, 1); do_reset();
    step(1'b1, 8'($urandom), acc);
    t0 = cyc;
    for (int i = 0; i < 3; i++) step(1'b1, 8'($urandom), acc);
    while (cyc < t0 + 1 + 70) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL mid_pre cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      step(1'b0, 8'($urandom), acc);
    end
    do_reset();
    checks++;
    if (obs !== 7'b1010000) begin
      errors++; $display("FAIL mid_after_rst got=%b exp=1010000", obs);
    end
    for (int k = 0; k < 400; k++) begin
      checks++;
      if (obs !== 7'b1010000) begin
        errors++; $display("FAIL mid_quiet cyc=%0d got=%b exp=1010000", cyc, obs);
      end
      step(1'b0, 8'($urandom), acc);
    end
    step(1'b1, 8'h3C, acc);
    for (int k = 0; k < 200; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL mid_post cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic test_min_rate();
    logic acc;
    int t0;
    int pat[10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
    sel = 2; set_cfg(2, 1); do_reset();
    step(1'b1, 8'h0F, acc);
    t0 = cyc;
    for (int k = 0; k < 40; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL minrate_vec cyc=%0d got=%b exp=%b", cyc, obs, exp_vec(cyc));
      end
      for (int i = 0; i < 10; i++) begin
        if (cyc == t0 + 1 + 2 * i || cyc == t0 + 2 + 2 * i) begin
          checks++;
          if (obs[6] !== 1'(pat[i])) begin
            errors++; $display("FAIL minrate_bit%0d got=%b exp=%0d", i, obs[6], pat[i]);
          end
        end
      end
      if (cyc == t0 + 21) begin
        checks++;
        if (obs[5] !== 1'b0) begin
          errors++; $display("FAIL minrate_busy got=%b exp=0", obs[5]);
        end
      end
      step(1'b0, 8'($urandom), acc);
    end
  endtask

  task automatic test_back_to_back(input int s, input int c, input int st, input int n);
    logic acc;
    logic v;
    int dense;
    sel = s; set_cfg(c, st); do_reset();
    dense = 0;
    for (int k = 0; k < n; k++) begin
      checks++;
      if (obs !== exp_vec(cyc)) begin
        errors++;
        $display("FAIL b2b_dut%0d cyc=%0d got=%b exp=%b", s, cyc, obs, exp_vec(cyc));
      end
      if (k % 150 == 0) dense = $urandom_range(0, 1);
      if (k > n - 12 * fl) v = 1'b0;
      else if (dense != 0) v = ($urandom_range(0, 3) != 0);
      else v = ($urandom_range(0, 40) == 0);
      step(v, 8'($urandom), acc);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0; wv = 1'b0; wd = 8'h00; sel = 0;
    set_cfg(16, 1);
    model_clear();
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_bit_order();
    test_full_fifo();
    test_two_stop();
    test_reset_mid();
    test_min_rate();
    test_back_to_back(0, 16, 1, 4000);
    test_back_to_back(1, 4, 2, 1500);
    test_back_to_back(2, 2, 1, 1000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_stim.md
# uart_tx_stim

Synthesizable UART transmitter with a small write FIFO. It drives the `uart0_rxd_i` input of the neorv32 test-setup top. Bytes written on a valid/ready port are serialised as 8N1 (or 8N2) frames, LSB first, at a fixed integer clock-per-bit ratio. The same block serves as the stimulus source in the iverilog bench and as an on-chip command source behind the JTAG data register path.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit. Legal range 2..65535. The bit timer is 16 bits.
- `DEPTH_LOG2`, default 3: the FIFO holds 2**DEPTH_LOG2 bytes, so 8 by default.
- `STOP_BITS`, default 1: number of stop bits, 1 or 2.

Ports:
- `clk_i` input 1: the single clock. All logic is on its rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `wdata_i` input 8: the byte to transmit.
- `wvalid_i` input 1: write request. A byte is accepted on an edge where `wvalid_i & wready_o` is high.
- `wready_o` output 1: equals `level_o != 2**DEPTH_LOG2`. It is combinational from the registered level.
- `level_o` output DEPTH_LOG2+1: number of bytes held in the FIFO. This count excludes the byte currently being shifted out.
- `busy_o` output 1: high while the FSM is not in IDLE.
- `txd_o` output 1: serial output, registered. Idle level is high.

## Operation
- **FIFO:** circular buffer with read and write pointers of DEPTH_LOG2 bits that wrap naturally, plus a level counter.
  - A push and a pop on the same edge leave the level unchanged.
  - A push while full cannot occur, because `wready_o` is low.
  - A pop while empty cannot occur, because the FSM pops only when `level_o != 0`.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** `txd_o`=1. If `level_o != 0`, pop the head byte into the 8-bit shift register, set `txd_o`=0, load the bit timer with CLKS_PER_BIT-1, and go to START.
  - **START:** hold `txd_o`=0 until the timer reaches 0. Then drive `txd_o` = shift[0], reload the timer, clear the bit counter, and go to DATA.
  - **DATA:** each time the timer reaches 0, shift right and increment the 3-bit bit counter. After bit 7 expires, drive `txd_o`=1, reload the timer, clear the stop counter, and go to STOP.
  - **STOP:** hold `txd_o`=1 for STOP_BITS × CLKS_PER_BIT cycles. At expiry:
    - if `level_o != 0`, pop the next byte, set `txd_o`=0, and go straight to START, with no idle gap;
    - otherwise go to IDLE.
- **Input handling:** `wdata_i` is never sampled unless the write is accepted. The frame in progress is unaffected by writes.
- **Reset:** at any point, including mid-frame, `rst_i` returns the FSM to IDLE. On the next edge it clears the pointers, level and timer and sets `txd_o`=1. Any partial frame is truncated.

## Timing
- **Reset values:** `txd_o`=1, `busy_o`=0, `level_o`=0, `wready_o`=1.
- **Accept to start bit:** a byte accepted at edge E0 into an empty FIFO, with the FSM in IDLE, is popped at E1. `txd_o` falls after E1, which is 1 cycle of latency. `busy_o` rises at E1, and `level_o` reads 1 between E0 and E1.
- **Bit periods:**
  - Every bit, start, data and stop, lasts exactly CLKS_PER_BIT cycles.
  - A frame lasts (9+STOP_BITS) × CLKS_PER_BIT cycles, which is 160 cycles at the defaults.
- **Back-to-back frames:** the next start bit begins on the cycle immediately after the last stop cycle. The start-bit spacing is exactly the frame length.
- **Return to idle:** `busy_o` falls on the same edge that the FSM enters IDLE. `txd_o` is already 1 at that point.
- **Counter width:** the bit timer counts down from CLKS_PER_BIT-1 to 0, so CLKS_PER_BIT=2 gives 2-cycle bits.

## Test plan
- **Single byte:** reset, then write 0x55 at t0. Expected response:
  - `txd_o` reads 0,1,0,1,0,1,0,1,0,1, each level for 16 cycles, starting at t0+1;
  - `busy_o` falls at t0+161;
  - `level_o` returns to 0 at t0+1.
- **Bit order:** write 0xA3. Expected data bits on the line, LSB first: 1,1,0,0,0,1,0,1. The frame is followed by 16 cycles of high and then idle high.
- **Full FIFO:** hold `wvalid_i`=1 with bytes 0x01..0x0A on consecutive cycles.
  - 9 bytes are accepted, at E0..E8; `level_o` reaches 8 at E8 and `wready_o` goes low.
  - At E161, 0x02 is popped with no idle gap; `wready_o` rises and 0x0A is accepted.
  - All 10 bytes appear on `txd_o` in order, with start bits exactly 160 cycles apart.
- **Two stop bits:** with STOP_BITS=2 and CLKS_PER_BIT=4, write 0xFF twice. Expected: 4 cycles low, then 40 cycles high, then the second start bit. Each frame is 44 cycles.
- **Reset mid-frame:** assert `rst_i` for 1 cycle during data bit 3 with 3 bytes queued.
  - `txd_o`=1, `level_o`=0, `busy_o`=0 from the next edge.
  - Nothing further is transmitted until a new write.
- **Minimum rate:** with CLKS_PER_BIT=2, write 0x0F. Expected: 20-cycle frame, with the pattern 0,1,1,1,1,0,0,0,0,1 at 2 cycles per bit.
